mux_rr_sched: RTL
=================

// Module: mux_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one 4:1 select mux (d[3:0], s[1:0], e -> y) among four requesters.
//  Drives the mux select and enable from a registered grant, holds ownership for one burst, then
//  inserts a turnaround gap before re-arbitrating. Sits directly in front of the 4:1 mux instance.
// PARAMETERS
//  TURNAROUND  1   extra en=0 cycles after a release, legal range 0..3
//  BURST_MAX   16  max cycles per grant, legal range 2..256; used only with MUX_SCHED_TIMEOUT_EN
// PORTS
//  clk      in   1  single clock, rising edge
//  rst_n    in   1  asynchronous active-low reset
//  req      in   4  request per requester, level, held until served
//  last     in   4  end-of-burst strobe per requester; only last[sel] is honoured
//  grant    out  4  one-hot grant, registered; 4'b0000 when idle or in gap
//  sel      out  2  mux select (to s), registered, index of current or most recent owner
//  en       out  1  mux enable (to e), registered; 1 only while a grant is active
//  busy     out  1  1 in OWN and GAP states
//  timeout  out  1  one-cycle pulse on forced release (only with MUX_SCHED_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, grant=0, sel=2'b00, en=0, busy=0, timeout=0, ptr=0, cnt=0, gcnt=0.
//  States: IDLE, OWN, GAP.
//  IDLE: if |req, pick the first set bit scanning ptr, ptr+1, ... (mod 4). Next edge: grant=onehot(k),
//   sel=k, en=1, cnt=0, state=OWN. Latency req->en is 1 cycle. No req: stay IDLE, outputs hold.
//  OWN: en=1, grant stable. cnt increments each cycle, saturating. Release occurs when last[sel]=1
//   or req[sel]=0. A last asserted in the first OWN cycle is valid, giving a 1-cycle burst.
//   last/req of non-owners is ignored.
//  Release edge: grant=0, en=0, sel holds, ptr=sel+1 (mod 4, 3 wraps to 0).
//   If TURNAROUND=0, state=IDLE. Otherwise state=GAP with gcnt=0.
//  GAP: en=0. After TURNAROUND cycles, state=IDLE. Minimum en=0 gap between two grants is TURNAROUND+1 cycles.
//  Fairness: the just-served requester has lowest priority on the next pick.
//   Any requester holding req continuously is granted within 3 other bursts.
//  Simultaneous last[sel] and req[sel]=0 count as one release.
//  A new req arriving during OWN/GAP is queued by level only; nothing is latched.
//  Invariant: en==|grant, and grant==onehot(sel) whenever en=1.
// CONFIGURATION
//  MUX_SCHED_TIMEOUT_EN defined:
//   - In OWN, when cnt==BURST_MAX-1 and no release is pending, force release at that edge.
//   - Timeout path: timeout=1 for one cycle (registered, concurrent with en falling), then the same
//     gap/ptr rules as a normal release.
//   - An owner therefore holds en for at most BURST_MAX cycles. A natural release on the limit cycle
//     wins, and timeout stays 0.
//  MUX_SCHED_TIMEOUT_EN undefined:
//   - No timeout port and no limit; grant is held until last[sel] or the owner drops req.
//   - BURST_MAX is unused and cnt may be omitted.
// STRUCTURE
//  Package mux_sched_pkg:
//   - N_REQ=4, SEL_W=2
//   - state encoding IDLE=2'd0, OWN=2'd1, GAP=2'd2
//   - function onehot4(sel)
//  Sub-module rr_pick4 (combinational): inputs req[3:0] and ptr[1:0]; outputs valid and idx[1:0].
//   The scheduler FSM, counters and output registers live in mux_rr_sched.
// TESTING
//  1 Reset mid-OWN (grant=4'b0100): assert rst_n=0 -> grant=0, en=0, sel=0 immediately.
//    Then req=4'b0100 -> grant=4'b0100 one cycle after release of reset.
//  2 req=4'b1111 held, last pulsed each OWN cycle, TURNAROUND=1 -> grant order 0001,0010,0100,1000,0001.
//    Each grant lasts 1 cycle, with 2 en=0 cycles between grants.
//  3 Owner 2 drops req without last -> release next edge, ptr=3. With req=4'b0011, next grant=4'b0001.
//  4 Owner 3 releases, ptr wraps to 0. With req=4'b1001, next grant=4'b0001, not 4'b1000.
//  5 last[1]=1 while owner=0 -> ignored, grant stays 4'b0001; check en==|grant every cycle.
//  6 MUX_SCHED_TIMEOUT_EN, BURST_MAX=4, owner 0 never asserts last -> en high exactly 4 cycles.
//    timeout pulses 1 cycle, then the next requester is granted.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// ---------------------------------------------------------------------------
// mux_sched_pkg
// Shared definitions for the round-robin 4:1 mux scheduler.
//   N_REQ          number of requesters (4)
//   SEL_W          width of the mux select (2)
//   sched_state_e  scheduler FSM states IDLE/OWN/GAP
//   onehot4()      select index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_sched_if.sv
// ---------------------------------------------------------------------------
// mux_rr_sched_if
// Request/grant bundle between four requesters and the mux scheduler.
//   req     requester -> scheduler, level request per requester
//   last    requester -> scheduler, end-of-burst strobe per requester
//   grant   scheduler -> requesters, one-hot grant
//   sel     scheduler -> mux s input
//   en      scheduler -> mux e input
//   busy    scheduler status (OWN or GAP)
//   timeout scheduler forced-release pulse (only with MUX_SCHED_TIMEOUT_EN)
// Modports: master = scheduler side, slave = requester side.
// Build option: `define MUX_SCHED_TIMEOUT_EN adds the timeout signal.
// ---------------------------------------------------------------------------
interface mux_rr_sched_if;
    import mux_sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] last;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic             busy;
`ifdef MUX_SCHED_TIMEOUT_EN
    logic             timeout;

    modport master (input req, last, output grant, sel, en, busy, timeout);
    modport slave  (output req, last, input grant, sel, en, busy, timeout);
`else
    modport master (input req, last, output grant, sel, en, busy);
    modport slave  (output req, last, input grant, sel, en, busy);
`endif

endinterface

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker: returns the first set request bit
// scanning ptr, ptr+1, ... (mod 4).
//   req   in  4  request vector
//   ptr   in  2  highest-priority index
//   valid out 1  at least one request set
//   idx   out 2  chosen index (ptr when no request)
// ---------------------------------------------------------------------------
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // SEL_W-bit addition wraps 3 -> 0 naturally
            cand = ptr + SEL_W'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// ---------------------------------------------------------------------------
// mux_rr_sched
// Round-robin scheduler sharing one 4:1 mux among four requesters. Grants
// one requester for a burst (until last[sel] or its req drops), then holds
// en low for TURNAROUND extra cycles before re-arbitrating. The requester
// just served gets lowest priority on the next pick.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    mux_rr_sched_if.master (req, last in; grant, sel, en, busy,
//          timeout out)
// Parameters:
//   TURNAROUND  0..3    extra en=0 cycles after a release
//   BURST_MAX   2..256  max grant length with MUX_SCHED_TIMEOUT_EN
// Build option: `define MUX_SCHED_TIMEOUT_EN enables the burst limit and
// the timeout pulse; without it a grant is held until released.
// ---------------------------------------------------------------------------
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int TURNAROUND = 1,
    parameter int BURST_MAX  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_rr_sched_if.master bus
);

    if (TURNAROUND < 0 || TURNAROUND > 3 || BURST_MAX < 2 || BURST_MAX > 256) begin : g_param_check
        $error("mux_rr_sched: TURNAROUND or BURST_MAX out of range");
    end

    localparam logic [1:0] GAP_LAST = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

    sched_state_e     r_state, w_state_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [SEL_W-1:0] r_sel,   w_sel_nxt;
    logic             r_en,    w_en_nxt;
    logic [SEL_W-1:0] r_ptr,   w_ptr_nxt;
    logic [1:0]       r_gcnt,  w_gcnt_nxt;
    logic             w_release;
    logic             w_pick_valid;
    logic [SEL_W-1:0] w_pick_idx;

`ifdef MUX_SCHED_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             w_force;
`endif

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_sel     <= '0;
            r_en      <= 1'b0;
            r_ptr     <= '0;
            r_gcnt    <= '0;
`ifdef MUX_SCHED_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_sel     <= w_sel_nxt;
            r_en      <= w_en_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gcnt    <= w_gcnt_nxt;
`ifdef MUX_SCHED_TIMEOUT_EN
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_sel_nxt     = r_sel;
        w_en_nxt      = r_en;
        w_ptr_nxt     = r_ptr;
        w_gcnt_nxt    = r_gcnt;
        w_release     = 1'b0;
`ifdef MUX_SCHED_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        w_force       = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = onehot4(w_pick_idx);
                    w_sel_nxt   = w_pick_idx;
                    w_en_nxt    = 1'b1;
`ifdef MUX_SCHED_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                    w_state_nxt = OWN;
                end
            end

            OWN: begin
                // last and a req drop at the same time are a single release
                w_release = bus.last[r_sel] | ~bus.req[r_sel];
`ifdef MUX_SCHED_TIMEOUT_EN
                // a natural release on the limit cycle takes precedence
                w_force   = ~w_release && (r_cnt == CNT_LAST);
                if (w_release || w_force) begin
                    w_timeout_nxt = w_force;
`else
                if (w_release) begin
`endif
                    w_grant_nxt = '0;
                    w_en_nxt    = 1'b0;
                    w_ptr_nxt   = r_sel + SEL_W'(1);
                    w_gcnt_nxt  = '0;
                    w_state_nxt = (TURNAROUND == 0) ? IDLE : GAP;
                end
`ifdef MUX_SCHED_TIMEOUT_EN
                else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end

            GAP: begin
                if (r_gcnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gcnt_nxt = r_gcnt + 2'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.grant   = r_grant;
    assign bus.sel     = r_sel;
    assign bus.en      = r_en;
    assign bus.busy    = (r_state != IDLE);
`ifdef MUX_SCHED_TIMEOUT_EN
    assign bus.timeout = r_timeout;
`endif

endmodule
